// File: rtl/io_pipe_pkg.sv
// Shared helpers for the I/O readiness pipe: port-window decode and the
// polarity of the ports' Empty/Full status bits.
package io_pipe_pkg;

  localparam logic EF_READ_HAS_DATA   = 1'b1;
  localparam logic EF_WRITE_HAS_SPACE = 1'b1;

  function automatic int unsigned port_addr_width(input int unsigned count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

  function automatic logic is_pow2(input int unsigned n);
    return (n != 0) && ((n & (n - 1)) == 0);
  endfunction

  function automatic logic io_port_hit(input int unsigned addr, input int unsigned base,
                                       input int unsigned count);
    return (addr >= base) && (addr < base + count);
  endfunction

  // Valid only because the port window base is aligned to the port count.
  function automatic int unsigned io_port_index(input int unsigned addr, input int unsigned count);
    return addr & (count - 1);
  endfunction

endpackage

// File: rtl/io_delay_line.sv
// Generic WIDTH x DEPTH shift register; synchronous reset clears every stage
// so nothing in flight survives a reset.
module io_delay_line #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/io_ready_pipe.sv
// I/O readiness and handshake unit for one data-memory side. Optional per-thread
// stall counters are built when IO_STALL_COUNT_EN is defined.
module io_ready_pipe
  import io_pipe_pkg::*;
#(
  parameter int unsigned WORD_WIDTH         = 36,
  parameter int unsigned ADDR_WIDTH         = 10,
  parameter int unsigned IO_PORT_COUNT      = 4,
  parameter int unsigned IO_PORT_BASE_ADDR  = 1020,
  parameter int unsigned PIPE_DEPTH         = 6,
  parameter int unsigned THREAD_COUNT       = 8,
  parameter int unsigned THREAD_COUNT_WIDTH = 3,
  parameter int unsigned STALL_COUNT_WIDTH  = 16
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                in_valid,
  input  logic                                in_cancel,
  input  logic [ADDR_WIDTH-1:0]               read_addr,
  input  logic [ADDR_WIDTH-1:0]               write_addr,
  input  logic [IO_PORT_COUNT-1:0]            io_read_EF,
  input  logic [IO_PORT_COUNT-1:0]            io_write_EF,
  input  logic [IO_PORT_COUNT*WORD_WIDTH-1:0] io_read_data,
  input  logic [WORD_WIDTH-1:0]               write_data_in,
  output logic [IO_PORT_COUNT-1:0]            io_rden,
  output logic [IO_PORT_COUNT-1:0]            io_wren,
  output logic [IO_PORT_COUNT*WORD_WIDTH-1:0] io_write_data,
  output logic [WORD_WIDTH-1:0]               read_data,
  output logic                                ior,
  output logic                                ior_previous,
  output logic                                cancel_previous,
  output logic [THREAD_COUNT_WIDTH-1:0]       thread_id,
  input  logic [THREAD_COUNT_WIDTH-1:0]       stall_thread_sel,
  output logic [STALL_COUNT_WIDTH-1:0]        stall_count
);

  localparam int unsigned PORT_ADDR_WIDTH = port_addr_width(IO_PORT_COUNT);
  localparam int unsigned DL_WIDTH        = 4 + PORT_ADDR_WIDTH;

  if (!is_pow2(IO_PORT_COUNT) || IO_PORT_COUNT < 2) begin : g_bad_port_count
    $error("io_ready_pipe: IO_PORT_COUNT must be a power of two and at least 2");
  end
  if ((IO_PORT_BASE_ADDR % IO_PORT_COUNT) != 0) begin : g_bad_base_addr
    $error("io_ready_pipe: IO_PORT_BASE_ADDR must be aligned to IO_PORT_COUNT");
  end
  if (PIPE_DEPTH < 1) begin : g_bad_depth
    $error("io_ready_pipe: PIPE_DEPTH must be at least 1");
  end

  logic                          read_hit_d, write_hit_d, ior_d;
  logic [PORT_ADDR_WIDTH-1:0]    rport_d, wport_d;
  logic                          valid_q, cancel_q, ior_q, read_hit_q, write_hit_q;
  logic [PORT_ADDR_WIDTH-1:0]    rport_q, wport_q;
  logic [THREAD_COUNT_WIDTH-1:0] thread_id_q, thread_id_d;
  logic [WORD_WIDTH-1:0]         read_data_q;
  logic [WORD_WIDTH-1:0]         rd_word [IO_PORT_COUNT];
  logic [DL_WIDTH-1:0]           dl_in, dl_out;
  logic                          dl_valid, dl_cancel, dl_ior, dl_hit;
  logic [PORT_ADDR_WIDTH-1:0]    dl_wport;
  logic                          rden_any, wren_any;

  always_comb begin
    read_hit_d  = io_port_hit(32'(read_addr), IO_PORT_BASE_ADDR, IO_PORT_COUNT);
    write_hit_d = io_port_hit(32'(write_addr), IO_PORT_BASE_ADDR, IO_PORT_COUNT);
    rport_d     = PORT_ADDR_WIDTH'(io_port_index(32'(read_addr), IO_PORT_COUNT));
    wport_d     = PORT_ADDR_WIDTH'(io_port_index(32'(write_addr), IO_PORT_COUNT));
    // Empty slots are never held back.
    ior_d = !in_valid ||
            ((!read_hit_d || (io_read_EF[rport_d] == EF_READ_HAS_DATA)) &&
             (!write_hit_d || (io_write_EF[wport_d] == EF_WRITE_HAS_SPACE)));
    thread_id_d = (thread_id_q == THREAD_COUNT_WIDTH'(THREAD_COUNT - 1)) ? '0
                                                                         : thread_id_q + 1'b1;
  end

  for (genvar p = 0; p < IO_PORT_COUNT; p++) begin : g_rd_word
    assign rd_word[p] = io_read_data[p*WORD_WIDTH +: WORD_WIDTH];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q     <= 1'b0;
      cancel_q    <= 1'b0;
      ior_q       <= 1'b0;
      read_hit_q  <= 1'b0;
      write_hit_q <= 1'b0;
      rport_q     <= '0;
      wport_q     <= '0;
      thread_id_q <= '0;
      read_data_q <= '0;
    end else begin
      valid_q     <= in_valid;
      cancel_q    <= in_cancel;
      ior_q       <= ior_d;
      read_hit_q  <= read_hit_d;
      write_hit_q <= write_hit_d;
      rport_q     <= rport_d;
      wport_q     <= wport_d;
      thread_id_q <= thread_id_d;
      read_data_q <= rd_word[rport_q];
    end
  end

  assign dl_in = {valid_q, cancel_q, ior_q, write_hit_q, wport_q};

  io_delay_line #(
    .WIDTH (DL_WIDTH),
    .DEPTH (PIPE_DEPTH)
  ) u_delay_line (
    .clock (clock),
    .reset (reset),
    .d_i   (dl_in),
    .q_o   (dl_out)
  );

  assign {dl_valid, dl_cancel, dl_ior, dl_hit, dl_wport} = dl_out;

  // An instruction with IOR low is annulled and re-issued, so it raises no enables.
  assign rden_any = valid_q && !cancel_q && ior_q && read_hit_q;
  assign wren_any = dl_valid && !dl_cancel && dl_ior && dl_hit;

  always_comb begin
    io_rden = '0;
    io_wren = '0;
    for (int p = 0; p < IO_PORT_COUNT; p++) begin
      io_rden[p] = rden_any && (rport_q == PORT_ADDR_WIDTH'(p));
      io_wren[p] = wren_any && (dl_wport == PORT_ADDR_WIDTH'(p));
    end
  end

  assign io_write_data   = {IO_PORT_COUNT{write_data_in}};
  assign read_data       = read_data_q;
  assign ior             = ior_q;
  assign ior_previous    = dl_ior;
  assign cancel_previous = dl_cancel;
  assign thread_id       = thread_id_q;

`ifdef IO_STALL_COUNT_EN
  logic [STALL_COUNT_WIDTH-1:0] stall_cnt_q [THREAD_COUNT];
  logic [STALL_COUNT_WIDTH-1:0] stall_count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < THREAD_COUNT; i++) stall_cnt_q[i] <= '0;
      stall_count_q <= '0;
    end else begin
      if (valid_q && !cancel_q && !ior_q && (stall_cnt_q[thread_id_q] != '1))
        stall_cnt_q[thread_id_q] <= stall_cnt_q[thread_id_q] + 1'b1;
      stall_count_q <= stall_cnt_q[stall_thread_sel];
    end
  end

  assign stall_count = stall_count_q;
`else
  logic unused_stall_sel;
  assign unused_stall_sel = ^stall_thread_sel;
  assign stall_count      = '0;
`endif

endmodule

// File: tb/tb_io_ready_pipe.sv
// Randomised and directed bench for io_ready_pipe against a per-cycle history
// model built from the port-window, IOR and pipeline-latency rules.
module tb_io_ready_pipe;

  localparam int W    = 36;
  localparam int AW   = 10;
  localparam int PC   = 4;
  localparam int BASE = 1020;
  localparam int PD   = 6;
  localparam int TC   = 8;
  localparam int TW   = 3;
  localparam int SW   = 16;
  localparam int NCYC = 1200;

  logic clock, reset, in_valid, in_cancel;
  logic [AW-1:0]   read_addr, write_addr;
  logic [PC-1:0]   io_read_EF, io_write_EF, io_rden, io_wren;
  logic [PC*W-1:0] io_read_data, io_write_data;
  logic [W-1:0]    write_data_in, read_data;
  logic            ior, ior_previous, cancel_previous;
  logic [TW-1:0]   thread_id, stall_thread_sel;
  logic [SW-1:0]   stall_count;

  io_ready_pipe #(
    .WORD_WIDTH(W), .ADDR_WIDTH(AW), .IO_PORT_COUNT(PC), .IO_PORT_BASE_ADDR(BASE),
    .PIPE_DEPTH(PD), .THREAD_COUNT(TC), .THREAD_COUNT_WIDTH(TW), .STALL_COUNT_WIDTH(SW)
  ) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_cancel(in_cancel),
    .read_addr(read_addr), .write_addr(write_addr), .io_read_EF(io_read_EF),
    .io_write_EF(io_write_EF), .io_read_data(io_read_data), .write_data_in(write_data_in),
    .io_rden(io_rden), .io_wren(io_wren), .io_write_data(io_write_data),
    .read_data(read_data), .ior(ior), .ior_previous(ior_previous),
    .cancel_previous(cancel_previous), .thread_id(thread_id),
    .stall_thread_sel(stall_thread_sel), .stall_count(stall_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit              rst;
    bit              valid;
    bit              cancel;
    int              raddr;
    int              waddr;
    bit [PC-1:0]     r_ef;
    bit [PC-1:0]     w_ef;
    logic [PC*W-1:0] rdata;
  } slot_t;

  slot_t hist [NCYC];
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  int    thr_m = 0;
  int    cnt_m [TC];
  logic [SW-1:0] exp_stall = '0;

  bit              g_rst, g_v, g_c;
  int              g_ra, g_wa;
  bit [PC-1:0]     g_ref, g_wef;
  logic [PC*W-1:0] g_rd;
  logic [W-1:0]    g_wd;

  function automatic bit hit(input int a);
    return (a >= BASE) && (a < BASE + PC);
  endfunction

  function automatic bit ready(input slot_t s);
    if (!s.valid) return 1'b1;
    return (!hit(s.raddr) || s.r_ef[s.raddr-BASE]) && (!hit(s.waddr) || s.w_ef[s.waddr-BASE]);
  endfunction

  function automatic slot_t get(input int i);
    slot_t s;
    if (i >= 0) return hist[i];
    s = '{rst: 1'b1, valid: 1'b0, cancel: 1'b0, raddr: 0, waddr: 0, r_ef: '0, w_ef: '0, rdata: '0};
    return s;
  endfunction

  function automatic logic [PC-1:0] onehot(input int idx);
    logic [PC-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_outputs();
    slot_t p1, p2, ps, t;
    bit rst_any;
    int s;
    logic [PC-1:0] e;
    p1 = get(cyc - 1);
    p2 = get(cyc - 2);
    thr_m = p1.rst ? 0 : (thr_m + 1) % TC;
    check("ior", ior, (!p1.rst && ready(p1)) ? 64'd1 : 64'd0);
    e = '0;
    if (!p1.rst && p1.valid && !p1.cancel && ready(p1) && hit(p1.raddr)) e = onehot(p1.raddr - BASE);
    check("io_rden", io_rden, e);
    check("thread_id", thread_id, thr_m);
    if (p1.rst) check("read_data_rst", read_data, 0);
    else if (!p2.rst && p2.valid && !p2.cancel && ready(p2) && hit(p2.raddr))
      check("read_data", read_data, p1.rdata[(p2.raddr-BASE)*W +: W]);
    s = cyc - 1 - PD;
    rst_any = 1'b0;
    for (int i = s; i <= cyc - 1; i++) begin
      t = get(i);
      if (t.rst) rst_any = 1'b1;
    end
    ps = get(s);
    check("ior_previous", ior_previous, (!rst_any && ready(ps)) ? 64'd1 : 64'd0);
    check("cancel_previous", cancel_previous, (!rst_any && ps.cancel) ? 64'd1 : 64'd0);
    e = '0;
    if (!rst_any && ps.valid && !ps.cancel && ready(ps) && hit(ps.waddr)) e = onehot(ps.waddr - BASE);
    check("io_wren", io_wren, e);
    check("stall_count", stall_count, exp_stall);
  endtask

  task automatic step();
    slot_t cur, p1;
    int p, sel;
    @(negedge clock);
    if (cyc >= NCYC) begin
      $display("FAIL history_overflow cycle %0d limit %0d", cyc, NCYC);
      $fatal(1, "bench history exhausted");
    end
    check_outputs();
    sel = $urandom_range(0, TC - 1);
    reset = g_rst; in_valid = g_v; in_cancel = g_v & g_c;
    read_addr = AW'(g_ra); write_addr = AW'(g_wa);
    io_read_EF = g_ref; io_write_EF = g_wef; io_read_data = g_rd;
    write_data_in = g_wd; stall_thread_sel = TW'(sel);
    cur = '{rst: g_rst, valid: g_v, cancel: g_v & g_c, raddr: g_ra, waddr: g_wa,
            r_ef: g_ref, w_ef: g_wef, rdata: g_rd};
    hist[cyc] = cur;
`ifdef IO_STALL_COUNT_EN
    exp_stall = cur.rst ? '0 : SW'(cnt_m[sel]);
    if (cur.rst) begin
      for (int i = 0; i < TC; i++) cnt_m[i] = 0;
    end else begin
      p1 = get(cyc - 1);
      if (!p1.rst && p1.valid && !p1.cancel && !ready(p1) && cnt_m[thr_m] < (1 << SW) - 1)
        cnt_m[thr_m]++;
    end
`else
    p1 = get(cyc - 1);
    exp_stall = '0;
`endif
    #1;
    p = $urandom_range(0, PC - 1);
    check("io_write_data", io_write_data[p*W +: W], g_wd);
    cyc++;
  endtask

  task automatic idle(input int n);
    g_v = 1'b0; g_c = 1'b0; g_rst = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    for (int i = 0; i < TC; i++) cnt_m[i] = 0;
    g_rst = 1'b1; g_v = 1'b0; g_c = 1'b0; g_ra = 0; g_wa = 0;
    g_ref = '0; g_wef = '0; g_rd = '0; g_wd = '0;
    reset = 1'b1; in_valid = 1'b0; in_cancel = 1'b0; read_addr = '0; write_addr = '0;
    io_read_EF = '0; io_write_EF = '0; io_read_data = '0; write_data_in = '0;
    stall_thread_sel = '0;
    for (int i = 0; i < 3; i++) step();

    // Read hit on port 1 with data present.
    g_rd = '0; g_rd[1*W +: W] = 36'hABC;
    g_rst = 0; g_v = 1; g_c = 0; g_ra = 1021; g_wa = 5; g_ref = 4'b0010; g_wef = '0;
    step(); idle(8);

    // Read from empty port 2 stalls.
    g_v = 1; g_ra = 1022; g_wa = 5; g_ref = 4'b1011;
    step(); idle(8);

    // Write to port 3 with space; result arrives at write-back.
    g_v = 1; g_ra = 0; g_wa = 1023; g_wef = 4'b1000; g_wd = 36'h123;
    step(); idle(8);

    // Cancelled instruction with both ports ready.
    g_v = 1; g_c = 1; g_ra = 1020; g_wa = 1023; g_ref = '1; g_wef = '1;
    step(); idle(8);

    // Write in flight killed by reset.
    g_v = 1; g_ra = 3; g_wa = 1023; g_wef = 4'b1000;
    step(); idle(2);
    g_rst = 1; step();
    idle(10);

    // Non-I/O addresses right after reset; thread_id walks 0..7,0,1.
    g_rst = 1; step();
    g_rst = 0; g_v = 1; g_c = 0; g_ra = 0; g_wa = 5;
    for (int i = 0; i < 10; i++) step();
    idle(8);

    for (int n = 0; n < 700; n++) begin
      g_rst = ($urandom_range(0, 99) == 0);
      g_v   = ($urandom_range(0, 3) != 0);
      g_c   = ($urandom_range(0, 4) == 0);
      g_ra  = $urandom_range(0, 1) ? BASE + int'($urandom_range(0, PC - 1)) : int'($urandom_range(0, 1023));
      g_wa  = $urandom_range(0, 1) ? BASE + int'($urandom_range(0, PC - 1)) : int'($urandom_range(0, 1023));
      g_ref = PC'($urandom);
      g_wef = PC'($urandom);
      for (int p = 0; p < PC; p++) g_rd[p*W +: W] = W'({$urandom, $urandom});
      g_wd  = W'({$urandom, $urandom});
      step();
    end
    idle(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
